pwm_capture: RTL and testbench



---
 rtl/pwm_capture_if.sv | 16 +
 rtl/pwm_capture.sv | 159 +++++++++++++++
 tb/tb_pwm_capture.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_if.sv
// Register read port of pwm_capture, shared with the I2C register bank read path.
//
// Handshake: Rd_En is a single-cycle strobe with no back-pressure (there is no
// ready). Addr is sampled on the rising Clk edge where Rd_En=1. Rd_Data is
// registered on that same edge, so it is valid the cycle after the strobe, and
// it holds until the next strobe. Rd_En may be asserted on every cycle.
// Dbg_State mirrors the per-channel capture FSM (bit ch = 1 while ch is HIGH).
interface pwm_capture_if;
    logic       Rd_En;
    logic [7:0] Addr;
    logic [7:0] Rd_Data;
    logic [7:0] Dbg_State;

    modport master (output Rd_En, output Addr, input Rd_Data, input Dbg_State);
    modport slave  (input Rd_En, input Addr, output Rd_Data, output Dbg_State);
endinterface

// File: rtl/pwm_capture.sv
// 8-channel servo/RC pulse-width capture with microsecond resolution.
// Each channel measures its high time in us ticks and raises Valid when a
// pulse completes. Valid drops after TIMEOUT_US us with no rising edge.
// Results are read through an 8-bit address / 8-bit data register map.
// The low byte of a width is read first: that read snapshots the high byte
// and Valid into a shadow register. The snapshot keeps the 16-bit read coherent.
// Optional macro PWM_CAPTURE_GLITCH_FILTER_EN adds a 3-sample stability
// filter after the synchronizer. The filter rejects pulses shorter than 3 Clk.
module pwm_capture #(
    parameter int US_DIV     = 50,
    parameter int TIMEOUT_US = 25000
) (
    input  logic          Clk,
    input  logic          rst_n,
    input  logic [7:0]    Pwm_In,
    output logic [7:0]    Valid,
    pwm_capture_if.slave  bus
);

    localparam logic [0:0]  ST_IDLE  = 1'b0;
    localparam logic [0:0]  ST_HIGH  = 1'b1;
    localparam logic [7:0]  DIV_LAST = 8'(US_DIV - 1);
    localparam logic [14:0] TO_LAST  = 15'(TIMEOUT_US - 1);
    localparam logic [14:0] SAT      = 15'h7FFF;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam logic [7:0]  CFG_BYTE = 8'h01;
`else
    localparam logic [7:0]  CFG_BYTE = 8'h00;
`endif

    logic [7:0]  div_cnt;
    logic        tick;
    logic [7:0]  sync1, sync2, lvl_prev, lvl_cur, rise, fall;
    logic [7:0]  state;
    logic [14:0] wcnt     [8];
    logic [14:0] wcnt_inc [8];
    logic [14:0] width    [8];
    logic [14:0] tcnt     [8];
    logic [7:0]  shadow;
    logic [2:0]  rd_ch;

    assign tick          = (div_cnt == DIV_LAST);
    assign rise          = lvl_cur & ~lvl_prev;
    assign fall          = ~lvl_cur & lvl_prev;
    assign rd_ch         = bus.Addr[3:1];
    assign bus.Dbg_State = state;

    // Free-running 1 us tick divider
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n)    div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 8'd1;
    end

    // Two-flop synchronizer plus previous-level register for edge detection
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            lvl_prev <= '0;
        end else begin
            sync1    <= Pwm_In;
            sync2    <= sync1;
            lvl_prev <= lvl_cur;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic [7:0] hist1, hist2;

    // Sample history for the stability filter
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            hist1 <= '0;
            hist2 <= '0;
        end else begin
            hist1 <= sync2;
            hist2 <= hist1;
        end
    end

    // Filtered level moves only when three consecutive samples agree
    always_comb begin
        lvl_cur = (sync2 & hist1 & hist2) | (lvl_prev & (sync2 | hist1 | hist2));
    end
`else
    // Unfiltered: the synchronized level is used directly
    always_comb begin
        lvl_cur = sync2;
    end
`endif

    // Width counter incremented by this cycle's tick, saturating
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            wcnt_inc[i] = (tick && wcnt[i] != SAT) ? wcnt[i] + 15'd1 : wcnt[i];
        end
    end

    // Per-channel IDLE/HIGH capture FSM, width latch, timeout and Valid
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= '0;
            Valid <= '0;
            for (int i = 0; i < 8; i++) begin
                wcnt[i]  <= '0;
                width[i] <= '0;
                tcnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                // Timeout: one-shot clear at the moment the count reaches TIMEOUT_US
                if (rise[i]) begin
                    tcnt[i] <= '0;
                end else if (tick && tcnt[i] != SAT) begin
                    tcnt[i] <= tcnt[i] + 15'd1;
                    if (tcnt[i] == TO_LAST) Valid[i] <= 1'b0;
                end
                // Capture FSM; a completing pulse overrides a same-cycle timeout
                if (rise[i]) begin
                    state[i] <= ST_HIGH;
                    wcnt[i]  <= '0;
                end else if (state[i] == ST_HIGH) begin
                    if (fall[i]) begin
                        state[i] <= ST_IDLE;
                        width[i] <= wcnt_inc[i];
                        Valid[i] <= 1'b1;
                    end else begin
                        wcnt[i]  <= wcnt_inc[i];
                    end
                end
            end
        end
    end

    // Register read port with low-byte-triggered shadow snapshot
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.Rd_Data <= '0;
            shadow      <= '0;
        end else if (bus.Rd_En) begin
            if (bus.Addr[7:4] == 4'h0) begin
                if (!bus.Addr[0]) begin
                    bus.Rd_Data <= width[rd_ch][7:0];
                    shadow      <= {Valid[rd_ch], width[rd_ch][14:8]};
                end else begin
                    bus.Rd_Data <= shadow;
                end
            end else if (bus.Addr == 8'h10) begin
                bus.Rd_Data <= Valid;
            end else if (bus.Addr == 8'h11) begin
                bus.Rd_Data <= CFG_BYTE;
            end else begin
                bus.Rd_Data <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture. It uses a shortened us tick and timeout so
// the whole run stays short.
module tb_pwm_capture;

    localparam int US_DIV     = 4;
    localparam int TIMEOUT_US = 3000;

    logic       Clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] Pwm_In;
    logic [7:0] Valid;

    pwm_capture_if bus ();

    pwm_capture #(.US_DIV(US_DIV), .TIMEOUT_US(TIMEOUT_US)) dut (
        .Clk    (Clk),
        .rst_n  (rst_n),
        .Pwm_In (Pwm_In),
        .Valid  (Valid),
        .bus    (bus)
    );

    // Clock / reset
    always #5 Clk = ~Clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q    [$];
    logic [7:0] exp_hi_q [$];
    string      tag_q    [$];

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] lo, input logic [7:0] hi);
        checks++;
        assert (!$isunknown(obs) && obs >= lo && obs <= hi)
        else begin
            errors++;
            $error("FAIL %s observed=0x%02h expected=0x%02h..0x%02h", tag, obs, lo, hi);
        end
    endtask

    task automatic push_exp(input string tag, input logic [7:0] lo, input logic [7:0] hi);
        exp_q.push_back(lo);
        exp_hi_q.push_back(hi);
        tag_q.push_back(tag);
    endtask

    task automatic pop_cmp();
        logic [7:0] lo, hi;
        string      tag;
        lo  = exp_q.pop_front();
        hi  = exp_hi_q.pop_front();
        tag = tag_q.pop_front();
        chk(tag, bus.Rd_Data, lo, hi);
    endtask

    // Single register read; expectation queued at drive time, checked on output
    task automatic drive_read(input logic [7:0] a, input logic [7:0] lo,
                              input logic [7:0] hi, input string tag);
        push_exp(tag, lo, hi);
        @(posedge Clk); #1;
        bus.Rd_En = 1'b1;
        bus.Addr  = a;
        @(posedge Clk); #1;
        bus.Rd_En = 1'b0;
        pop_cmp();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Pulse on the channels in mask, high for exactly us microseconds
    task automatic pulse(input logic [7:0] mask, input int us);
        @(posedge Clk); #1;
        Pwm_In = Pwm_In | mask;
        wait_cycles(us * US_DIV);
        Pwm_In = Pwm_In & ~mask;
        wait_cycles(8);
    endtask

    initial begin
        Pwm_In    = 8'h00;
        bus.Rd_En = 1'b0;
        bus.Addr  = 8'h00;

        // Reset state
        wait_cycles(4);
        chk("rst_rd_data", bus.Rd_Data, 8'h00, 8'h00);
        chk("rst_valid", Valid, 8'h00, 8'h00);
        chk("rst_state", bus.Dbg_State, 8'h00, 8'h00);
        rst_n = 1'b1;
        wait_cycles(4);
        for (int a = 0; a <= 'h11; a++) begin
            drive_read(8'(a), 8'h00, 8'h00, $sformatf("rst_reg_%02h", a));
        end

        // 1500 us on ch0: width 0x05DB..0x05DC, shadow 0x85
        @(posedge Clk); #1;
        Pwm_In = 8'h01;
        wait_cycles(10);
        chk("ch0_state_high", bus.Dbg_State, 8'h01, 8'h01);
        wait_cycles(1500 * US_DIV - 10);
        Pwm_In = 8'h00;
        wait_cycles(8);
        chk("ch0_state_idle", bus.Dbg_State, 8'h00, 8'h00);
        chk("ch0_valid", Valid, 8'h01, 8'h01);
        drive_read(8'h00, 8'hDB, 8'hDC, "ch0_lo");
        drive_read(8'h01, 8'h85, 8'h85, "ch0_hi");

        // Snapshot coherence: read low, new 1200 us capture, then read high
        drive_read(8'h00, 8'hDB, 8'hDC, "snap_lo");
        pulse(8'h01, 1200);
        drive_read(8'h01, 8'h85, 8'h85, "snap_hi_old");
        drive_read(8'h00, 8'hAF, 8'hB0, "ch0_1200_lo");
        drive_read(8'h01, 8'h84, 8'h84, "ch0_1200_hi");

        // Timeout on ch2: Valid drops, width held
        pulse(8'h04, 100);
        chk("ch2_valid_set", Valid, 8'h05, 8'h05);
        wait_cycles((TIMEOUT_US + 10) * US_DIV);
        chk("timeout_valid", Valid, 8'h00, 8'h00);
        drive_read(8'h04, 8'h63, 8'h64, "ch2_held_lo");
        drive_read(8'h05, 8'h00, 8'h00, "ch2_held_hi");
        drive_read(8'h10, 8'h00, 8'h00, "timeout_reg10");

        // ch3 1000 us and ch7 2000 us starting together
        @(posedge Clk); #1;
        Pwm_In = 8'h88;
        wait_cycles(1000 * US_DIV);
        Pwm_In = 8'h80;
        wait_cycles(1000 * US_DIV);
        Pwm_In = 8'h00;
        wait_cycles(8);
        drive_read(8'h06, 8'hE7, 8'hE8, "ch3_lo");
        drive_read(8'h07, 8'h83, 8'h83, "ch3_hi");
        drive_read(8'h0E, 8'hCF, 8'hD0, "ch7_lo");
        drive_read(8'h0F, 8'h87, 8'h87, "ch7_hi");
        drive_read(8'h10, 8'h88, 8'h88, "dual_reg10");
        wait_cycles(200 * US_DIV);

        // Next ch2 pulse restores its Valid
        pulse(8'h04, 100);
        chk("ch2_restored", Valid, 8'h8C, 8'h8C);
        drive_read(8'h04, 8'h63, 8'h64, "ch2_new_lo");
        drive_read(8'h05, 8'h80, 8'h80, "ch2_new_hi");

        // Back-to-back strobes: 0x10 then 0x12 (unmapped)
        push_exp("b2b_reg10", 8'h8C, 8'h8C);
        push_exp("b2b_unmapped", 8'h00, 8'h00);
        @(posedge Clk); #1;
        bus.Rd_En = 1'b1;
        bus.Addr  = 8'h10;
        @(posedge Clk); #1;
        bus.Addr  = 8'h12;
        pop_cmp();
        @(posedge Clk); #1;
        bus.Rd_En = 1'b0;
        pop_cmp();
        wait_cycles(3);
        chk("rd_data_hold", bus.Rd_Data, 8'h00, 8'h00);

        // 2-Clk glitch on ch1
        @(posedge Clk); #1;
        Pwm_In = 8'h02;
        wait_cycles(2);
        Pwm_In = 8'h00;
        wait_cycles(10);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        chk("glitch_valid", Valid, 8'h8C, 8'h8C);
        drive_read(8'h11, 8'h01, 8'h01, "cfg_byte");
        drive_read(8'h02, 8'h00, 8'h00, "glitch_lo");
        drive_read(8'h03, 8'h00, 8'h00, "glitch_hi");
`else
        // A us tick may fall inside the 2-Clk window, so 0 or 1 is legal
        chk("glitch_valid", Valid, 8'h8E, 8'h8E);
        drive_read(8'h11, 8'h00, 8'h00, "cfg_byte");
        drive_read(8'h02, 8'h00, 8'h01, "glitch_lo");
        drive_read(8'h03, 8'h80, 8'h80, "glitch_hi");
`endif

        chk("queue_drained", 8'(exp_q.size()), 8'h00, 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
